// File: rtl/icon_overlay_reader_if.sv
// Video stream, overlay controls and icon ROM port bundle.
// Master drives video/controls/ROM data; slave is the overlay block.
interface icon_overlay_reader_if #(
   parameter int ADDR_W  = 11,
   parameter int COORD_W = 12,
   parameter int PIX_W   = 24
);
   logic               i_vs;
   logic               i_hs;
   logic               i_de;
   logic [PIX_W-1:0]   i_data;
   logic               overlay_en;
   logic [COORD_W-1:0] pos_x;
   logic [COORD_W-1:0] pos_y;
   logic [PIX_W-1:0]   fg_color;
   logic [ADDR_W-1:0]  rom_addr;
   logic [7:0]         rom_data;
   logic               o_vs;
   logic               o_hs;
   logic               o_de;
   logic [PIX_W-1:0]   o_data;

   modport master (
      output i_vs, i_hs, i_de, i_data,
      output overlay_en, pos_x, pos_y, fg_color,
      output rom_data,
      input  rom_addr,
      input  o_vs, o_hs, o_de, o_data
   );

   modport slave (
      input  i_vs, i_hs, i_de, i_data,
      input  overlay_en, pos_x, pos_y, fg_color,
      input  rom_data,
      output rom_addr,
      output o_vs, o_hs, o_de, o_data
   );
endinterface

// File: rtl/icon_overlay_reader.sv
// Keys a 1-bpp icon from a sync ROM into a video stream.
// Video is delayed 3 cycles to line up with the ROM read.
module icon_overlay_reader #(
   parameter int ICON_W  = 128,
   parameter int ICON_H  = 128,
   parameter int ADDR_W  = 11,
   parameter int COORD_W = 12,
   parameter int PIX_W   = 24
) (
   input logic                  clk,
   input logic                  rst,
   icon_overlay_reader_if.slave vid
);
   typedef logic [COORD_W-1:0] coord_t;

   coord_t            x_cnt, y_cnt;
   coord_t            px_l, py_l;
   coord_t            dx, dy, row_base;
   logic [PIX_W-1:0]  fg_l;
   logic              en_l, frame_valid;
   logic              vs_q, de_q;
   logic              vs_rise, de_fall, hit;
   logic [ADDR_W-1:0] addr_next;
   logic              hit_d1, hit_d2;
   logic [2:0]        idx_d1, idx_d2;
   logic [2:0]        sync_d1, sync_d2;
   logic [PIX_W-1:0]  data_d1, data_d2;
   logic              icon_bit;

   // Unsigned wrap makes pixels left of / above the icon a miss.
   always_comb begin
      vs_rise   = vid.i_vs & ~vs_q;
      de_fall   = de_q & ~vid.i_de;
      dx        = x_cnt - px_l;
      dy        = y_cnt - py_l;
      row_base  = dy * coord_t'(ICON_W / 8);
      addr_next = ADDR_W'(row_base + (dx >> 3));
      hit       = vid.i_de & en_l & frame_valid
                & (dx < coord_t'(ICON_W))
                & (dy < coord_t'(ICON_H));
      icon_bit  = vid.rom_data[3'd7 - idx_d2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         px_l        <= '0;
         py_l        <= '0;
         fg_l        <= '0;
         en_l        <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         vs_q <= vid.i_vs;
         de_q <= vid.i_de;
         if (vs_rise) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            px_l        <= vid.pos_x;
            py_l        <= vid.pos_y;
            fg_l        <= vid.fg_color;
            en_l        <= vid.overlay_en;
            frame_valid <= 1'b1;
         end else if (de_fall) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
         end else if (vid.i_de) begin
            x_cnt <= x_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vid.rom_addr <= '0;
         hit_d1       <= 1'b0;
         hit_d2       <= 1'b0;
         idx_d1       <= '0;
         idx_d2       <= '0;
         sync_d1      <= '0;
         sync_d2      <= '0;
         data_d1      <= '0;
         data_d2      <= '0;
         vid.o_vs     <= 1'b0;
         vid.o_hs     <= 1'b0;
         vid.o_de     <= 1'b0;
         vid.o_data   <= '0;
      end else begin
         if (hit)
            vid.rom_addr <= addr_next;
         hit_d1  <= hit;
         hit_d2  <= hit_d1;
         idx_d1  <= dx[2:0];
         idx_d2  <= idx_d1;
         sync_d1 <= {vid.i_vs, vid.i_hs, vid.i_de};
         sync_d2 <= sync_d1;
         data_d1 <= vid.i_data;
         data_d2 <= data_d1;
         vid.o_vs   <= sync_d2[2];
         vid.o_hs   <= sync_d2[1];
         vid.o_de   <= sync_d2[0];
         vid.o_data <= (hit_d2 & icon_bit) ? fg_l : data_d2;
      end
   end
endmodule

// File: tb/tb_icon_overlay_reader.sv
// Directed bench for icon_overlay_reader on a scaled 160x8 frame
// with a 128x4 icon (64-byte ROM).
module tb_icon_overlay_reader;
   localparam int W  = 160;
   localparam int H  = 8;
   localparam int IW = 128;
   localparam int IH = 4;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icon_overlay_reader_if #(.ADDR_W(AW), .COORD_W(12), .PIX_W(24)) vif ();

   icon_overlay_reader #(
      .ICON_W(IW), .ICON_H(IH), .ADDR_W(AW), .COORD_W(12), .PIX_W(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vid(vif)
   );

   logic [7:0] rom [64];
   always_ff @(posedge clk) vif.rom_data <= rom[vif.rom_addr];

   int          checks   = 0;
   int          failures = 0;
   logic [26:0] pipe [3];
   logic        fv, vs_prev, m_en, c_en;
   int          m_px, m_py, c_px, c_py;
   logic [23:0] m_fg, c_fg;
   int          fr = 0;
   int          fgcnt;
   logic        addr_moved, chk_addr;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] model(logic vs, logic hs, logic de,
                                         logic [23:0] d, int x, int y);
      int dx, dy;
      logic [7:0] bv;
      logic b;
      dx = x - m_px;
      dy = y - m_py;
      b  = 1'b0;
      if (de && fv && m_en && dx >= 0 && dx < IW && dy >= 0 && dy < IH) begin
         bv = rom[dy * (IW / 8) + dx / 8];
         b  = bv[7 - dx % 8];
      end
      return {vs, hs, de, b ? m_fg : d};
   endfunction

   task automatic cycle(logic vs, logic hs, logic de, int x, int y);
      logic [23:0] d;
      logic [26:0] e;
      d = de ? {fr[7:0], y[7:0], x[7:0]} : 24'h0;
      vif.i_vs       = vs;
      vif.i_hs       = hs;
      vif.i_de       = de;
      vif.i_data     = d;
      vif.overlay_en = c_en;
      vif.pos_x      = 12'(c_px);
      vif.pos_y      = 12'(c_py);
      vif.fg_color   = c_fg;
      if (vs && !vs_prev) begin
         fv   = 1'b1;
         m_en = c_en;
         m_px = c_px;
         m_py = c_py;
         m_fg = c_fg;
      end
      vs_prev = vs;
      e = model(vs, hs, de, d, x, y);
      @(posedge clk);
      #1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
      chk($sformatf("pix f%0d y%0d x%0d", fr, y, x),
          32'({vif.o_vs, vif.o_hs, vif.o_de, vif.o_data}), 32'(pipe[2]));
      if (vif.o_de && vif.o_data == c_fg) fgcnt++;
      if (vif.rom_addr != '0) addr_moved = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_outs", 32'({vif.o_vs, vif.o_hs, vif.o_de, vif.o_data}), 32'd0);
      chk("rst_addr", 32'(vif.rom_addr), 32'd0);
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      fv      = 1'b0;
      vs_prev = 1'b0;
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic drive_frame(int rst_line, int chg_line, int chg_px);
      fr++;
      fgcnt = 0;
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 0, 0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 0, 0);
      for (int y = 0; y < H; y++) begin
         if (y == rst_line) do_reset();
         if (y == chg_line) c_px = chg_px;
         repeat (2) cycle(1'b0, 1'b1, 1'b0, 0, y);
         repeat (2) cycle(1'b0, 1'b0, 1'b0, 0, y);
         for (int x = 0; x < W; x++) begin
            cycle(1'b0, 1'b0, 1'b1, x, y);
            if (chk_addr && y == 1 && x == 8)
               chk("addr_l1_x8", 32'(vif.rom_addr), 32'd17);
         end
         repeat (2) cycle(1'b0, 1'b0, 1'b0, 0, y);
      end
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic fill_rom(logic [7:0] v);
      for (int i = 0; i < 64; i++) rom[i] = v;
   endtask

   initial begin
      rst = 1'b1;
      vif.i_vs = 1'b0; vif.i_hs = 1'b0; vif.i_de = 1'b0;
      vif.i_data = '0; vif.overlay_en = 1'b0;
      vif.pos_x = '0; vif.pos_y = '0; vif.fg_color = '0;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      fv = 1'b0; vs_prev = 1'b0; m_en = 1'b0; m_px = 0; m_py = 0; m_fg = '0;
      c_en = 1'b0; c_px = 0; c_py = 0; c_fg = '0;
      chk_addr = 1'b0; addr_moved = 1'b0; fgcnt = 0;
      fill_rom(8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 32'({vif.o_vs, vif.o_hs, vif.o_de, vif.o_data}), 32'd0);
      chk("reset_addr", 32'(vif.rom_addr), 32'd0);
      rst = 1'b0;

      // overlay disabled: pure 3-cycle pass-through, ROM never addressed
      fill_rom(8'hFF);
      c_en = 1'b0; c_px = 10; c_py = 2; c_fg = 24'hFF0000;
      addr_moved = 1'b0;
      drive_frame(-1, -1, 0);
      chk("off_addr_moved", 32'(addr_moved), 32'd0);
      chk("off_fgcnt", 32'(fgcnt), 32'd0);

      // full icon at (10,2): x 10..137, lines 2..5
      c_en = 1'b1;
      drive_frame(-1, -1, 0);
      chk("full_fgcnt", 32'(fgcnt), 32'd512);

      // single MSB bit at origin
      fill_rom(8'h00);
      rom[0] = 8'h80;
      c_px = 0; c_py = 0; c_fg = 24'h00FF00;
      chk_addr = 1'b1;
      drive_frame(-1, -1, 0);
      chk_addr = 1'b0;
      chk("origin_fgcnt", 32'(fgcnt), 32'd1);

      // right-edge clip: columns 100..159 only
      fill_rom(8'hFF);
      c_px = 100; c_py = 0; c_fg = 24'h0000FF;
      drive_frame(-1, -1, 0);
      chk("clipx_fgcnt", 32'(fgcnt), 32'd240);

      // bottom-edge clip: lines 6..7 only
      c_px = 0; c_py = 6;
      drive_frame(-1, -1, 0);
      chk("clipy_fgcnt", 32'(fgcnt), 32'd256);

      // mid-frame position change applies from the next frame
      c_px = 10; c_py = 2; c_fg = 24'hFF0000;
      drive_frame(-1, 3, 30);
      chk("chg_cur_fgcnt", 32'(fgcnt), 32'd512);
      drive_frame(-1, -1, 0);
      chk("chg_next_fgcnt", 32'(fgcnt), 32'd512);

      // reset at line 4: lines 2..3 drawn, then pass-through
      c_px = 10;
      drive_frame(4, -1, 0);
      chk("rst_mid_fgcnt", 32'(fgcnt), 32'd256);
      drive_frame(-1, -1, 0);
      chk("rst_next_fgcnt", 32'(fgcnt), 32'd512);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/icon_overlay_reader.md
Name: icon_overlay_reader

Overview:
- Consumes the 1-bpp fruit-icon ROM (11-bit address, 8-bit data, 1-cycle synchronous read) and blends the icon into the HDMI video stream.
- Placement: between the ISP output and the HDMI encoder, after fruit classification.
- Generates ROM addresses from live pixel coordinates and delays the video to match ROM latency.
- Keys a solid foreground colour wherever an icon bit is 1.

Parameters:
- ICON_W, 128, icon width in pixels; must be a multiple of 8.
- ICON_H, 128, icon height in pixels; ICON_W*ICON_H/8 = 2^ADDR_W.
- ADDR_W, 11, ROM address width.
- COORD_W, 12, width of the pixel/line counters and position inputs.
- PIX_W, 24, video pixel width (RGB888).

Ports:
- clk  in  1  pixel clock; shared with the ROM.
- rst  in  1  asynchronous, active-high reset.
- i_vs  in  1  vertical sync, active high.
- i_hs  in  1  horizontal sync, active high.
- i_de  in  1  data enable.
- i_data  in  PIX_W  input pixel.
- overlay_en  in  1  enables the icon (classifier hit).
- pos_x  in  COORD_W  icon left column, active-area coordinates.
- pos_y  in  COORD_W  icon top line.
- fg_color  in  PIX_W  colour for icon bits = 1.
- rom_addr  out  ADDR_W  address to the icon ROM.
- rom_data  in  8  ROM read data, valid 1 cycle after rom_addr is sampled.
- o_vs, o_hs, o_de  out  1 each  delayed syncs.
- o_data  out  PIX_W  blended pixel.

Behaviour:
- Reset: all outputs, counters and pipeline registers are 0; frame_valid = 0.
- Counters:
  - x_cnt increments on each i_de=1 cycle and clears on the i_de falling edge.
  - y_cnt increments on the i_de falling edge and clears on the i_vs rising edge.
- Frame latch: on the i_vs rising edge, register pos_x, pos_y, fg_color and overlay_en, and set frame_valid = 1. Changes mid-frame take effect only from the next frame.
- Before the first i_vs after reset, no overlay is drawn (frame_valid = 0).
- Hit condition (stage 0): i_de & en_l & frame_valid & x_cnt-px_l < ICON_W & y_cnt-py_l < ICON_H.
  - Use unsigned COORD_W subtraction. A negative result wraps to a large value and counts as a miss.
  - Icons extending past the active area are clipped naturally.
- Address: rom_addr is registered at the end of stage 0 and equals (y_cnt-py_l)*(ICON_W/8) + (x_cnt-px_l)[COORD_W-1:3].
  - On a miss, rom_addr holds its previous value.
- Pipeline:
  - stage 0 = input cycle N.
  - stage 1 = rom_addr presented in cycle N+1.
  - stage 2 = rom_data valid in cycle N+2.
  - stage 3 = registered outputs in cycle N+3.
- Bit alignment:
  - The hit flag and bit index (x_cnt-px_l)[2:0] are delayed 2 cycles to align with rom_data.
  - Select bit rom_data[7-idx]: MSB is the leftmost pixel.
- Blend: o_data = (hit_d2 & bit) ? fg_color_l : data_d2. Registered.
- Latency: o_vs, o_hs, o_de and o_data are i_* delayed by exactly 3 cycles, with or without a hit. Syncs are never modified.
- Simultaneous events: an i_vs rising edge coinciding with i_de=1 is a protocol error; the counter clear takes priority.
- Position latch at 0,0: the icon starts at the first active pixel.
- Reset mid-frame: the pipeline flushes to 0, and output resumes pass-through after the next i_vs.

Test Plan:
- Reset, then a 1280x720 frame with overlay_en=0 -> o_data equals i_data delayed 3 cycles, rom_addr stays 0, and o_de/o_hs/o_vs match i_* delayed 3.
- overlay_en=1, pos=(100,50), ROM all 0xFF, fg_color=24'hFF0000 -> exactly pixels x 100..227 on lines 50..177 become FF0000; all others pass through.
- ROM byte 0 = 0x80, others 0, pos=(0,0) -> only pixel (0,0) is fg_color; rom_addr for line 1, x=8 is 17.
- pos_x=1200 -> columns 1200..1279 overlaid, no wrap onto the next line; pos_y=700 -> lines 700..719 only.
- pos_x changed from 100 to 300 mid-frame -> the current frame still draws at 100; the next frame draws at 300.
- Assert rst at line 300 -> all outputs 0 on the next cycle; after release, no overlay until the next i_vs rising edge, then normal overlay.
